// File: rtl/vbuf_chain.sv
// Elastic word buffer: a DEPTH-entry circular FIFO with one cycle of latency, or a
// combinational pass-through. A mode change is applied only once the buffer is empty.
module vbuf_chain #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bypass,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       mode
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_mode;

    logic [PW-1:0]    w_wptr_inc;
    logic [PW-1:0]    w_rptr_inc;
    logic [CW-1:0]    w_count_next;
    logic             w_mode_next;
    logic             w_push;
    logic             w_pop;

    assign w_wptr_inc = (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
    assign w_rptr_inc = (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;

    // Handshake outputs. While flushing nothing moves in either direction, so the
    // pass-through also withholds out_valid rather than offer a word it cannot take.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = r_mem[r_rptr];
        if (r_mode) begin
            in_ready  = out_ready && !flush && !rst;
            out_valid = in_valid && !flush;
            out_data  = in_data;
        end else begin
            in_ready  = !rst && !flush && ((r_count != FULL_CNT) || out_ready);
            out_valid = (r_count != '0);
        end
    end

    assign w_push = in_valid && in_ready && !r_mode;
    assign w_pop  = out_valid && out_ready && !r_mode && !flush;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
        if (flush) begin
            w_count_next = '0;
        end
        // The transparent path stores nothing, so its count stays zero and bypass is
        // followed every edge; in registered mode it waits for the buffer to drain.
        w_mode_next = (w_count_next == '0) ? bypass : r_mode;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_mode  <= w_mode_next;
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= w_wptr_inc;
                if (w_pop)  r_rptr <= w_rptr_inc;
            end
        end
    end

    // Storage needs no reset: the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    assign count = r_count;
    assign mode  = r_mode;

endmodule

// File: tb/tb_vbuf_chain.sv
// Bench for vbuf_chain: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based model of the buffer.
module tb_vbuf_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             bypass;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;
    logic             mode;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] mq[$];
    logic             m_mode = 1'b0;

    vbuf_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bypass(bypass), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .mode(mode)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected outputs from the model state and the inputs currently applied.
    function automatic void model_out(output logic ir, output logic ov,
                                      output logic [WIDTH-1:0] od, output int cnt,
                                      output logic md);
        ir = 1'b0; ov = 1'b0; od = '0; cnt = 0; md = 1'b0;
        if (rst) return;
        if (m_mode) begin
            ir = out_ready && !flush;
            ov = in_valid && !flush;
            od = in_data;
            md = 1'b1;
        end else begin
            cnt = mq.size();
            ov  = (cnt != 0);
            if (ov) od = mq[0];
            ir  = !flush && ((cnt < DEPTH) || out_ready);
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        logic ir, ov, md;
        logic [WIDTH-1:0] od;
        int cnt;
        if (rst) begin
            mq.delete();
            m_mode = 1'b0;
        end else begin
            model_out(ir, ov, od, cnt, md);
            if (flush) begin
                mq.delete();
                m_mode = bypass;
            end else if (!m_mode) begin
                if (ov && out_ready) void'(mq.pop_front());
                if (in_valid && ir) mq.push_back(in_data);
                if (mq.size() == 0) m_mode = bypass;
            end else begin
                m_mode = bypass;
            end
        end
    end

    always @(negedge clk) begin
        logic ir, ov, md;
        logic [WIDTH-1:0] od;
        int cnt;
        model_out(ir, ov, od, cnt, md);
        chk("mode", 32'(mode), 32'(md));
        chk("count", 32'(count), 32'(cnt));
        chk("in_ready", 32'(in_ready), 32'(ir));
        chk("out_valid", 32'(out_valid), 32'(ov));
        if (ov) chk("out_data", 32'(out_data), 32'(od));
        $display("cyc t=%0t rst=%0b byp=%0b fl=%0b iv=%0b ir=%0b id=%02h ov=%0b or=%0b od=%02h cnt=%0d mode=%0b",
                 $time, rst, bypass, flush, in_valid, in_ready, in_data, out_valid,
                 out_ready, out_data, count, mode);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + WIDTH'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bypass = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mode", 32'(mode), 0);
        rst = 1'b0;

        // Latency: push 0x11 with out_ready=1.
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_valid = 1'b0;
        chk("lat_out_valid", 32'(out_valid), 1);
        chk("lat_out_data", 32'(out_data), 32'h11);
        tick();
        chk("lat_count_after", 32'(count), 0);

        // Fill and wrap.
        out_ready = 1'b0;
        push_n(4, 8'hA0);
        in_valid = 1'b1; in_data = 8'hA4;
        #1;
        chk("fill_count", 32'(count), 4);
        chk("fill_in_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", 32'(in_ready), 1);
        chk("wrap_word0", 32'(out_data), 32'hA0);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("wrap_word%0d", k), 32'(out_data), 32'(8'hA0 + k));
            tick();
        end
        chk("wrap_drained", 32'(count), 0);

        // Full pass-through for 10 cycles.
        out_ready = 1'b0;
        push_n(4, 8'hB0);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 8'hC0 + 8'(k);
            #1;
            chk("pass_in_ready", 32'(in_ready), 1);
            tick();
            chk("pass_count", 32'(count), 4);
        end
        in_valid = 1'b0;
        repeat (4) tick();

        // Deferred mode change.
        out_ready = 1'b0;
        push_n(2, 8'hD0);
        bypass = 1'b1;
        tick();
        chk("defer_mode_cnt2", 32'(mode), 0);
        out_ready = 1'b1;
        tick();
        chk("defer_mode_cnt1", 32'(mode), 0);
        tick();
        chk("defer_mode_now", 32'(mode), 1);
        in_valid = 1'b1; in_data = 8'h77;
        #1;
        chk("bypass_out_valid", 32'(out_valid), 1);
        chk("bypass_out_data", 32'(out_data), 32'h77);
        tick();
        in_valid = 1'b0; bypass = 1'b0;
        tick();
        chk("back_to_reg", 32'(mode), 0);

        // Flush priority.
        out_ready = 1'b0;
        push_n(3, 8'hE0);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'hEE;
        #1;
        chk("flush_in_ready", 32'(in_ready), 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_out_valid", 32'(out_valid), 0);

        // Asynchronous reset between edges.
        out_ready = 1'b0;
        push_n(2, 8'hF0);
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        tick();
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("arst_push_valid", 32'(out_valid), 1);
        chk("arst_push_data", 32'(out_data), 32'h5A);
        tick();

        // Random traffic checked by the per-cycle compare process.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 8'($urandom);
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 40) == 0;
            if (($urandom % 50) == 0) bypass = ~bypass;
            rst       = ($urandom % 500) == 0;
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
